lifo_stack: RTL and testbench

LIFO_STACK -- requirements
Module: lifo_stack

---
 rtl/stack_pkg.sv | 21 ++
 rtl/stack_mem.sv | 35 +++
 rtl/lifo_stack.sv | 146 ++++++++++++++
 tb/tb_lifo_stack.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stack_pkg
// Brief    : Shared defaults and {PUSH,POP} operation encoding for lifo_stack.
// Revision : 1.0 - initial release
// ============================================================================
package stack_pkg;

    localparam int c_data_width = 8;
    localparam int c_depth      = 3;

    // Encoding matches the concatenation {PUSH, POP}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_SWAP = 2'b11
    } stack_op_e;

endpackage
`default_nettype wire

// File: rtl/stack_mem.sv
`default_nettype none
// ============================================================================
// Module   : stack_mem
// Brief    : Un-reset storage array, one write port, two async read ports.
// Revision : 1.0 - initial release
// ============================================================================
module stack_mem
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int DEPTH      = c_depth
) (
    input  logic                  CLK,
    input  logic                  WE,
    input  logic [DEPTH-1:0]      WADDR,
    input  logic [DATA_WIDTH-1:0] WDATA,
    input  logic [DEPTH-1:0]      RADDR_TOP,
    output logic [DATA_WIDTH-1:0] RDATA_TOP,
    input  logic [DEPTH-1:0]      RADDR_AUX,
    output logic [DATA_WIDTH-1:0] RDATA_AUX
);

    logic [DATA_WIDTH-1:0] r_mem [2**DEPTH];

    always_ff @(posedge CLK) begin
        if (WE) begin
            r_mem[WADDR] <= WDATA;
        end
    end

    assign RDATA_TOP = r_mem[RADDR_TOP];
    assign RDATA_AUX = r_mem[RADDR_AUX];

endmodule
`default_nettype wire

// File: rtl/lifo_stack.sv
`default_nettype none
// ============================================================================
// Module   : lifo_stack
// Brief    : Saturating LIFO with registered pop data and sticky error flags.
// Revision : 1.0 - initial release
// ============================================================================
module lifo_stack
    import stack_pkg::*;
#(
    parameter int DATA_WIDTH = c_data_width,
    parameter int DEPTH      = c_depth,
    parameter int AF_LEVEL   = (2**DEPTH) - 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  PUSH,
    input  logic                  POP,
    input  logic                  CLR_ERR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  VALID_OUT,
    output logic [DATA_WIDTH-1:0] PEEK,
    output logic [DEPTH:0]        COUNT,
    output logic                  EMPTY,
    output logic                  FULL,
    output logic                  ALMOST_FULL,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW
);

    localparam logic [DEPTH:0] c_full_count = (DEPTH+1)'(2**DEPTH);
    localparam logic [DEPTH:0] c_af_count   = (DEPTH+1)'(AF_LEVEL);
    localparam logic [DEPTH:0] c_one        = (DEPTH+1)'(1);

    logic [DEPTH:0]        r_count;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_valid;
    logic                  r_ovf;
    logic                  r_udf;

    logic [DEPTH:0]        w_count_m1;
    logic [DEPTH-1:0]      w_top_addr;
    logic [DATA_WIDTH-1:0] w_top_data;
    logic [DATA_WIDTH-1:0] w_unused_aux;
    logic                  w_empty;
    logic                  w_full;
    stack_op_e             w_op;

    logic [DEPTH:0]        w_count_nxt;
    logic [DATA_WIDTH-1:0] w_data_out_nxt;
    logic                  w_valid_nxt;
    logic                  w_we;
    logic [DEPTH-1:0]      w_waddr;
    logic                  w_ovf_set;
    logic                  w_udf_set;

    assign w_op       = stack_op_e'({PUSH, POP});
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_full_count);
    assign w_count_m1 = r_count - c_one;
    assign w_top_addr = w_count_m1[DEPTH-1:0];

    always_comb begin
        w_count_nxt    = r_count;
        w_data_out_nxt = r_data_out;
        w_valid_nxt    = 1'b0;
        w_we           = 1'b0;
        w_waddr        = r_count[DEPTH-1:0];
        w_ovf_set      = 1'b0;
        w_udf_set      = 1'b0;
        case (w_op)
            OP_PUSH: begin
                if (w_full) begin
                    w_ovf_set = 1'b1;
                end else begin
                    w_we        = 1'b1;
                    w_count_nxt = r_count + c_one;
                end
            end
            OP_POP: begin
                if (w_empty) begin
                    w_udf_set = 1'b1;
                end else begin
                    w_data_out_nxt = w_top_data;
                    w_valid_nxt    = 1'b1;
                    w_count_nxt    = w_count_m1;
                end
            end
            OP_SWAP: begin
                // Empty stack: the pushed word passes straight through
                w_valid_nxt = 1'b1;
                if (w_empty) begin
                    w_data_out_nxt = DATA_IN;
                end else begin
                    w_data_out_nxt = w_top_data;
                    w_we           = 1'b1;
                    w_waddr        = w_top_addr;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count    <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
            r_ovf      <= 1'b0;
            r_udf      <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_data_out <= w_data_out_nxt;
            r_valid    <= w_valid_nxt;
            // A new error event takes priority over a clear
            r_ovf      <= w_ovf_set | (r_ovf & ~CLR_ERR);
            r_udf      <= w_udf_set | (r_udf & ~CLR_ERR);
        end
    end

    stack_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_stack_mem (
        .CLK       (CLK),
        .WE        (w_we),
        .WADDR     (w_waddr),
        .WDATA     (DATA_IN),
        .RADDR_TOP (w_top_addr),
        .RDATA_TOP (w_top_data),
        .RADDR_AUX ('0),
        .RDATA_AUX (w_unused_aux)
    );

    assign DATA_OUT    = r_data_out;
    assign VALID_OUT   = r_valid;
    assign PEEK        = w_empty ? '0 : w_top_data;
    assign COUNT       = r_count;
    assign EMPTY       = w_empty;
    assign FULL        = w_full;
    assign ALMOST_FULL = (r_count >= c_af_count);
    assign OVERFLOW    = r_ovf;
    assign UNDERFLOW   = r_udf;

endmodule
`default_nettype wire

// File: tb/tb_lifo_stack.sv
`default_nettype none
// ============================================================================
// Module   : tb_lifo_stack
// Brief    : Directed scenarios plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lifo_stack;

    localparam int N = 8;

    logic       CLK = 1'b0;
    logic       RST;
    logic       PUSH, POP, CLR_ERR;
    logic [7:0] DATA_IN;
    logic [7:0] DATA_OUT, PEEK;
    logic [3:0] COUNT;
    logic       VALID_OUT, EMPTY, FULL, ALMOST_FULL, OVERFLOW, UNDERFLOW;

    int tests_run    = 0;
    int tests_failed = 0;

    // Behavioural model: queue back is the top of stack
    logic [7:0] q[$];
    logic [7:0] m_dout;
    logic       m_valid, m_ovf, m_udf;

    lifo_stack #(.DATA_WIDTH(8), .DEPTH(3), .AF_LEVEL(7)) dut (
        .CLK(CLK), .RST(RST), .PUSH(PUSH), .POP(POP), .CLR_ERR(CLR_ERR),
        .DATA_IN(DATA_IN), .DATA_OUT(DATA_OUT), .VALID_OUT(VALID_OUT),
        .PEEK(PEEK), .COUNT(COUNT), .EMPTY(EMPTY), .FULL(FULL),
        .ALMOST_FULL(ALMOST_FULL), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    function automatic logic [7:0] m_peek();
        return (q.size() == 0) ? 8'h00 : q[q.size()-1];
    endfunction

    task automatic model_reset();
        q.delete();
        m_dout  = 8'h00;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
    endtask

    // Apply one operation across a rising edge and advance the model
    task automatic cycle(input logic psh, input logic pp, input logic clr, input logic [7:0] din);
        logic ovf_ev, udf_ev;
        PUSH = psh; POP = pp; CLR_ERR = clr; DATA_IN = din;
        @(posedge CLK);
        ovf_ev  = 1'b0;
        udf_ev  = 1'b0;
        m_valid = 1'b0;
        if (psh && pp) begin
            m_valid = 1'b1;
            if (q.size() == 0) m_dout = din;
            else begin
                m_dout = q[q.size()-1];
                q[q.size()-1] = din;
            end
        end else if (psh) begin
            if (q.size() == N) ovf_ev = 1'b1;
            else q.push_back(din);
        end else if (pp) begin
            if (q.size() == 0) udf_ev = 1'b1;
            else begin
                m_dout  = q.pop_back();
                m_valid = 1'b1;
            end
        end
        m_ovf = ovf_ev | (m_ovf & ~clr);
        m_udf = udf_ev | (m_udf & ~clr);
        #1;
        PUSH = 1'b0; POP = 1'b0; CLR_ERR = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; PUSH = 0; POP = 0; CLR_ERR = 0; DATA_IN = 8'h00;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        tests_run++;
        if ({COUNT, DATA_OUT, VALID_OUT, OVERFLOW, UNDERFLOW, EMPTY, FULL, PEEK} !== {4'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00}) begin
            tests_failed++;
            $display("FAIL reset_state: got cnt=%0d dout=%h v=%b ovf=%b udf=%b e=%b f=%b peek=%h, want 0 00 0 0 0 1 0 00",
                     COUNT, DATA_OUT, VALID_OUT, OVERFLOW, UNDERFLOW, EMPTY, FULL, PEEK);
        end
        RST = 1'b0;
    endtask

    task automatic test_fill();
        for (int i = 0; i < N; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 8'(8'h11 * (i + 1)));
            tests_run++;
            if (COUNT !== 4'(i + 1) || ALMOST_FULL !== (i + 1 >= 7)) begin
                tests_failed++;
                $display("FAIL fill_count[%0d]: got cnt=%0d af=%b, want cnt=%0d af=%b",
                         i, COUNT, ALMOST_FULL, i + 1, (i + 1 >= 7));
            end
        end
        tests_run++;
        if (FULL !== 1'b1 || PEEK !== 8'h88) begin
            tests_failed++;
            $display("FAIL fill_full: got full=%b peek=%h, want 1 88", FULL, PEEK);
        end
    endtask

    task automatic test_overflow_drain();
        cycle(1'b1, 1'b0, 1'b0, 8'h99);
        tests_run++;
        if (OVERFLOW !== 1'b1 || COUNT !== 4'd8 || PEEK !== 8'h88) begin
            tests_failed++;
            $display("FAIL overflow: got ovf=%b cnt=%0d peek=%h, want 1 8 88", OVERFLOW, COUNT, PEEK);
        end
        for (int i = 0; i < N; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 8'h00);
            tests_run++;
            if (DATA_OUT !== 8'(8'h11 * (8 - i)) || VALID_OUT !== 1'b1) begin
                tests_failed++;
                $display("FAIL drain_pop[%0d]: got dout=%h v=%b, want %h 1", i, DATA_OUT, VALID_OUT, 8'(8'h11 * (8 - i)));
            end
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (EMPTY !== 1'b1 || VALID_OUT !== 1'b0 || DATA_OUT !== 8'h11) begin
            tests_failed++;
            $display("FAIL drain_idle: got e=%b v=%b dout=%h, want 1 0 11", EMPTY, VALID_OUT, DATA_OUT);
        end
    endtask

    task automatic test_underflow_clr();
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (UNDERFLOW !== 1'b1 || VALID_OUT !== 1'b0 || DATA_OUT !== 8'h11) begin
            tests_failed++;
            $display("FAIL underflow: got udf=%b v=%b dout=%h, want 1 0 11", UNDERFLOW, VALID_OUT, DATA_OUT);
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
        tests_run++;
        if (OVERFLOW !== 1'b0 || UNDERFLOW !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_err: got ovf=%b udf=%b, want 0 0", OVERFLOW, UNDERFLOW);
        end
        cycle(1'b0, 1'b1, 1'b1, 8'h00);
        tests_run++;
        if (UNDERFLOW !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_vs_event: got udf=%b, want 1", UNDERFLOW);
        end
        cycle(1'b0, 1'b0, 1'b1, 8'h00);
    endtask

    task automatic test_swap();
        cycle(1'b1, 1'b0, 1'b0, 8'hA1);
        cycle(1'b1, 1'b0, 1'b0, 8'hA2);
        cycle(1'b1, 1'b1, 1'b0, 8'hB0);
        tests_run++;
        if ({DATA_OUT, VALID_OUT, COUNT, PEEK, OVERFLOW, UNDERFLOW} !== {8'hA2, 1'b1, 4'd2, 8'hB0, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL swap: got dout=%h v=%b cnt=%0d peek=%h ovf=%b udf=%b, want a2 1 2 b0 0 0",
                     DATA_OUT, VALID_OUT, COUNT, PEEK, OVERFLOW, UNDERFLOW);
        end
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (DATA_OUT !== 8'hB0) begin
            tests_failed++;
            $display("FAIL swap_pop: got dout=%h, want b0", DATA_OUT);
        end
        cycle(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic test_bypass();
        cycle(1'b1, 1'b1, 1'b0, 8'h5C);
        tests_run++;
        if ({DATA_OUT, VALID_OUT, COUNT, EMPTY, PEEK, OVERFLOW, UNDERFLOW} !== {8'h5C, 1'b1, 4'd0, 1'b1, 8'h00, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL bypass: got dout=%h v=%b cnt=%0d e=%b peek=%h ovf=%b udf=%b, want 5c 1 0 1 00 0 0",
                     DATA_OUT, VALID_OUT, COUNT, EMPTY, PEEK, OVERFLOW, UNDERFLOW);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 8'($urandom));
        tests_run++;
        if (COUNT !== 4'd5) begin
            tests_failed++;
            $display("FAIL pre_reset_count: got %0d, want 5", COUNT);
        end
        #2 RST = 1'b1;
        #1;
        model_reset();
        tests_run++;
        if ({COUNT, EMPTY, DATA_OUT, PEEK, VALID_OUT} !== {4'd0, 1'b1, 8'h00, 8'h00, 1'b0}) begin
            tests_failed++;
            $display("FAIL async_reset: got cnt=%0d e=%b dout=%h peek=%h v=%b, want 0 1 00 00 0",
                     COUNT, EMPTY, DATA_OUT, PEEK, VALID_OUT);
        end
        @(posedge CLK);
        #2 RST = 1'b0;
        cycle(1'b1, 1'b0, 1'b0, 8'h3E);
        tests_run++;
        if (PEEK !== 8'h3E || COUNT !== 4'd1) begin
            tests_failed++;
            $display("FAIL post_reset_push: got peek=%h cnt=%0d, want 3e 1", PEEK, COUNT);
        end
    endtask

    task automatic test_random();
        logic [25:0] got, exp;
        for (int i = 0; i < 400; i++) begin
            // Bias alternates between filling and draining phases
            int push_pct;
            push_pct = ((i / 50) % 2 == 0) ? 70 : 30;
            cycle($urandom_range(0, 99) < push_pct, $urandom_range(0, 99) >= push_pct,
                  $urandom_range(0, 99) < 5, 8'($urandom));
            got = {COUNT, DATA_OUT, VALID_OUT, PEEK, EMPTY, FULL, ALMOST_FULL, OVERFLOW, UNDERFLOW};
            exp = {4'(q.size()), m_dout, m_valid, m_peek(), q.size() == 0, q.size() == N,
                   q.size() >= N - 1, m_ovf, m_udf};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL random[%0d]: got {cnt,dout,v,peek,e,f,af,ovf,udf}=%h, want %h", i, got, exp);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow_drain();
        test_underflow_clr();
        test_swap();
        test_bypass();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
